// File: rtl/hs_rx_fifo_pkg.sv
// hs_rx_fifo_pkg
//   Shared definitions for the handshake receive FIFO:
//     - hs_state_e : handshake FSM state encoding (IDLE=1'b0, WAIT_LOW=1'b1)
//     - clog2()    : constant function sizing pointer and occupancy widths
package hs_rx_fifo_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } hs_state_e;

  // Ceiling log2, usable in parameter/port width expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hs_rx_fifo_sync.sv
// sync_ff
//   Multi-flop synchroniser for a single asynchronous level signal.
//   All flops clear to 0 on reset.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronised output (last flop of the chain)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Stage 0 samples d; each following stage samples its predecessor.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          sync_reg[gi] <= d;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo
//   Receives words from an asynchronous four-phase (req/ack) bundled-data
//   producer, buffers them in a DEPTH-entry FIFO and presents them to a
//   synchronous valid/ready consumer.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_req, in_data    : four-phase request and bundled data (async to clk)
//   in_ack             : registered four-phase acknowledge
//   out_valid/out_data : FIFO head, valid while count != 0
//   out_ready          : consumer pops the head when out_valid is high
//   count              : FIFO occupancy, 0..DEPTH
// Optional build macro HS_RX_PARITY_EN adds:
//   in_par  : odd-parity bit over {in_data, in_par}
//   par_err : sticky flag, set when a word with bad parity is acked
module hs_rx_fifo
  import hs_rx_fifo_pkg::*;
#(
  parameter int WD          = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_req,
  input  logic [WD-1:0]         in_data,
  output logic                  in_ack,
  output logic                  out_valid,
  output logic [WD-1:0]         out_data,
  input  logic                  out_ready,
  output logic [clog2(DEPTH):0] count
`ifdef HS_RX_PARITY_EN
  ,
  input  logic                  in_par,
  output logic                  par_err
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  hs_state_e     state_reg;
  logic          ack_reg;
  logic          req_s;
  logic [WD-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          accept;
  logic          par_ok;
  logic          wr_en;
  logic          pop;

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_req),
    .q     (req_s)
  );

  // Full uses the registered (pre-edge) count, so a pop in the same cycle
  // frees a slot only for the following edge.
  assign full   = (count_reg == FULL_COUNT);
  assign accept = (state_reg == IDLE) && req_s && !full;

`ifdef HS_RX_PARITY_EN
  assign par_ok = ^{in_data, in_par};
`else
  assign par_ok = 1'b1;
`endif

  // A bad-parity word is still acked (accept) but never stored (wr_en).
  assign wr_en = accept && par_ok;
  assign pop   = out_valid && out_ready;

  // in_data is sampled on the edge that raises in_ack; ack has not risen
  // yet, so the bundled data is guaranteed stable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ack_reg   <= 1'b1;
            state_reg <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!req_s) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef HS_RX_PARITY_EN
  logic par_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_reg <= 1'b0;
    end else if (accept && !par_ok) begin
      par_err_reg <= 1'b1;
    end
  end

  assign par_err = par_err_reg;
`endif

  assign in_ack    = ack_reg;
  assign count     = count_reg;
  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr_reg];

endmodule

// File: tb/tb_hs_rx_fifo.sv
module tb_hs_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_req;
  logic [3:0] in_data;
  logic       in_ack;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [2:0] count;
`ifdef HS_RX_PARITY_EN
  logic       in_par;
  logic       par_err;
`endif

  int n_checks;
  int n_errors;

  logic       sb_en;
  logic [3:0] sb_q[$];

  hs_rx_fifo #(.WD(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
`ifdef HS_RX_PARITY_EN
    ,
    .in_par    (in_par),
    .par_err   (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [3:0] data;
    logic       rdy;
    logic       ack;
    logic       chk_vd;
    logic       vld;
    logic [3:0] dout;
    int         cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard check happens before the edge on which a pop takes effect.
  task automatic step();
    logic [3:0] head;
    if (sb_en) begin
      chk("conc_count_le1", int'(count <= 3'd1), 1);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pop", 1, 0);
        end else begin
          head = sb_q.pop_front();
          chk("sb_order", int'(out_data), int'(head));
          $display("pop data=%0h", out_data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic level, input int exp_lat, input string name);
    int n;
    n = 0;
    while (in_ack !== level && n < 20) begin
      step();
      n++;
    end
    chk(name, n, exp_lat);
  endtask

  // Full four-phase transfer; hold = extra cycles in_req stays high after ack.
  task automatic send_word(input logic [3:0] d, input int hold, input logic bad_par);
    in_data = d;
`ifdef HS_RX_PARITY_EN
    in_par = bad_par ? ^d : ~^d;
`endif
    in_req = 1'b1;
    wait_ack(1'b1, 3, "ack_rise_latency");
    if (sb_en && !bad_par) sb_q.push_back(d);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("ack_held", int'(in_ack), 1);
      chk("single_write", int'(count), 1);
    end
    in_req = 1'b0;
    wait_ack(1'b0, 3, "ack_fall_latency");
    $display("word %0h handshake done, count=%0d", d, count);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    sb_en     = 1'b0;
    rst_n     = 1'b0;
    in_req    = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
`ifdef HS_RX_PARITY_EN
    in_par    = 1'b0;
`endif

    //         req  data   rdy  ack  chk  vld  dout   cnt
    vecs[0] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0};
    vecs[1] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0};
    vecs[2] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1};
    vecs[3] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1};
    vecs[4] = '{1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 0};
    vecs[5] = '{1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 0};
    vecs[6] = '{1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0};

    // Reset for 3 cycles
    repeat (3) step();
    chk("rst_ack", int'(in_ack), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    step();

    // Single word, table driven
    for (int i = 0; i < 7; i++) begin
      in_req    = vecs[i].req;
      in_data   = vecs[i].data;
      out_ready = vecs[i].rdy;
`ifdef HS_RX_PARITY_EN
      in_par    = ~^vecs[i].data;
`endif
      step();
      $display("vec %0d: ack=%0b valid=%0b data=%0h count=%0d",
               i, in_ack, out_valid, out_data, count);
      chk("vec_ack", int'(in_ack), int'(vecs[i].ack));
      chk("vec_count", int'(count), vecs[i].cnt);
      if (vecs[i].chk_vd) begin
        chk("vec_valid", int'(out_valid), int'(vecs[i].vld));
        if (vecs[i].vld) chk("vec_data", int'(out_data), int'(vecs[i].dout));
      end
    end
    out_ready = 1'b0;

    // Fill to DEPTH, fifth word stalls
    for (int w = 1; w <= 4; w++) send_word(4'(w), 0, 1'b0);
    chk("fill_count", int'(count), 4);
    in_data = 4'h5;
`ifdef HS_RX_PARITY_EN
    in_par = ~^in_data;
`endif
    in_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("full_stall_ack", int'(in_ack), 0);
      chk("full_count", int'(count), 4);
    end
    chk("full_head", int'(out_data), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_when_full_ack", int'(in_ack), 0);
    chk("pop_when_full_count", int'(count), 3);
    step();
    chk("late_write_ack", int'(in_ack), 1);
    chk("late_write_count", int'(count), 4);
    in_req = 1'b0;
    wait_ack(1'b0, 3, "ack_fall_latency");
    out_ready = 1'b1;
    for (int w = 2; w <= 5; w++) begin
      chk("drain_order", int'(out_data), w);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", int'(count), 0);
    chk("drain_valid", int'(out_valid), 0);

    // Handshake protocol: in_req held long after ack
    send_word(4'h7, 10, 1'b0);
    chk("hold_count", int'(count), 1);
    chk("hold_data", int'(out_data), 7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_pop", int'(count), 0);

    // Concurrent push and pop, crossing pointer wrap twice
    sb_en = 1'b1;
    out_ready = 1'b1;
    for (int w = 0; w < 8; w++) send_word(4'(w + 8), 0, 1'b0);
    repeat (3) step();
    sb_en = 1'b0;
    out_ready = 1'b0;
    chk("conc_all_popped", sb_q.size(), 0);
    chk("conc_empty", int'(count), 0);

    // Reset while in WAIT_LOW with count=2
    send_word(4'hC, 0, 1'b0);
    in_data = 4'hD;
`ifdef HS_RX_PARITY_EN
    in_par = ~^in_data;
`endif
    in_req = 1'b1;
    wait_ack(1'b1, 3, "ack_rise_latency");
    chk("pre_reset_count", int'(count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", int'(in_ack), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    step();
    step();
    rst_n = 1'b1;
    wait_ack(1'b1, 3, "recapture_latency");
    chk("recapture_count", int'(count), 1);
    chk("recapture_data", int'(out_data), 13);
    in_req = 1'b0;
    wait_ack(1'b0, 3, "ack_fall_latency");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("recapture_pop", int'(count), 0);

`ifdef HS_RX_PARITY_EN
    chk("par_err_reset", int'(par_err), 0);
    send_word(4'h3, 0, 1'b1);
    chk("bad_par_count", int'(count), 0);
    chk("bad_par_flag", int'(par_err), 1);
    send_word(4'h5, 0, 1'b0);
    chk("good_par_count", int'(count), 1);
    chk("good_par_data", int'(out_data), 5);
    chk("par_err_sticky", int'(par_err), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
